// File: rtl/dz_tx_scanner_pkg.sv
// rtl/dz_tx_scanner_pkg.sv - shared types and constants for the DZ11 transmit scanner
package dz_tx_scanner_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_READY  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } scan_state_t;

endpackage

// File: rtl/dz_tx_scanner_if.sv
// rtl/dz_tx_scanner_if.sv - CSR/TCR/TBUF and transmitter-array signals of the transmit scanner
interface dz_tx_scanner_if
    import dz_tx_scanner_pkg::*;
#(
    parameter int NLINES = 8,
    parameter int LW     = (NLINES > 1) ? $clog2(NLINES) : 1
);
    logic              clr;
    logic              mse;
    logic              tie;
    logic [NLINES-1:0] tcr;
    logic [NLINES-1:0] empty;
    logic              tbufWR;
    logic [DATA_W-1:0] tbufDATA;
    logic              trdy;
    logic [LW-1:0]     tline;
    logic [NLINES-1:0] txload;
    logic [DATA_W-1:0] txdata;
    logic              tirq;

    modport master (
        output clr, mse, tie, tcr, empty, tbufWR, tbufDATA,
        input  trdy, tline, txload, txdata, tirq
    );

    modport slave (
        input  clr, mse, tie, tcr, empty, tbufWR, tbufDATA,
        output trdy, tline, txload, txdata, tirq
    );
endinterface

// File: rtl/dz_tx_scanner_line_decode.sv
// rtl/dz_tx_scanner_line_decode.sv - enabled one-hot decode of a line number
module dz_line_decode #(
    parameter int NLINES = 8,
    parameter int LW     = (NLINES > 1) ? $clog2(NLINES) : 1
) (
    input  logic [LW-1:0]     line,
    input  logic              en,
    output logic [NLINES-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[line] = 1'b1;
        end
    end
endmodule

// File: rtl/dz_tx_scanner.sv
// rtl/dz_tx_scanner.sv - round-robin search for an enabled, empty transmitter and TBUF steering
module dz_tx_scanner
    import dz_tx_scanner_pkg::*;
#(
    parameter int NLINES = 8,
    parameter int LW     = (NLINES > 1) ? $clog2(NLINES) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dz_tx_scanner_if.slave bus
);
    scan_state_t       state;
    logic [LW-1:0]     ptr;
    logic [NLINES-1:0] load_vec;

    function automatic logic [LW-1:0] next_line(input logic [LW-1:0] n);
        if (n == LW'(NLINES - 1)) begin
            return '0;
        end
        return n + 1'b1;
    endfunction

    // Strobe is formed from the registered tline, so it is valid only while READY holds it stable.
    dz_line_decode #(
        .NLINES(NLINES),
        .LW    (LW)
    ) u_decode (
        .line  (bus.tline),
        .en    ((state == ST_READY) && bus.tbufWR),
        .onehot(load_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SCAN;
            ptr        <= '0;
            bus.trdy   <= 1'b0;
            bus.tline  <= '0;
            bus.txload <= '0;
            bus.txdata <= '0;
            bus.tirq   <= 1'b0;
        end else if (bus.clr) begin
            state      <= ST_SCAN;
            ptr        <= '0;
            bus.trdy   <= 1'b0;
            bus.tline  <= '0;
            bus.txload <= '0;
            bus.txdata <= '0;
            bus.tirq   <= 1'b0;
        end else begin
            bus.tirq   <= 1'b0;
            bus.txload <= load_vec;
            case (state)
                ST_SCAN: begin
                    if (bus.mse) begin
                        if (bus.tcr[ptr] && bus.empty[ptr]) begin
                            bus.tline <= ptr;
                            bus.trdy  <= 1'b1;
                            bus.tirq  <= bus.tie;
                            state     <= ST_READY;
                        end else begin
                            ptr <= next_line(ptr);
                        end
                    end
                end
                ST_READY: begin
                    // A TBUF write wins over a simultaneous withdrawal of the line.
                    if (bus.tbufWR) begin
                        bus.txdata <= bus.tbufDATA;
                        bus.trdy   <= 1'b0;
                        state      <= ST_LOAD;
                    end else if (!bus.mse || !bus.tcr[bus.tline]) begin
                        bus.trdy <= 1'b0;
                        ptr      <= next_line(bus.tline);
                        state    <= ST_SCAN;
                    end
                end
                ST_LOAD: begin
                    ptr   <= next_line(bus.tline);
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Gives the loaded UART a cycle to drop empty before it can be matched again.
                    state <= ST_SCAN;
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dz_tx_scanner.sv
// tb/tb_dz_tx_scanner.sv - scoreboard bench for the DZ11 transmit scanner
module tb_dz_tx_scanner;
    localparam int NL = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [NL-1:0] exp_load_q[$];
    logic [7:0]    exp_data_q[$];

    dz_tx_scanner_if #(.NLINES(NL)) bus ();

    dz_tx_scanner #(.NLINES(NL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic service(input int line, input logic [7:0] d, input bit drop, input logic exp_irq);
        int         cyc;
        logic [NL-1:0] el;
        logic [7:0] ed;
        cyc = 0;
        while (bus.trdy !== 1'b1 && cyc < 2 * NL + 4) begin
            step();
            cyc++;
        end
        vectors++;
        if (bus.trdy !== 1'b1) begin
            miscompares++;
            $display("FAIL service_trdy line=%0d: trdy=%b after %0d cycles, required 1", line, bus.trdy, cyc);
        end
        vectors++;
        if (bus.tline !== 3'(line)) begin
            miscompares++;
            $display("FAIL service_tline: tline=%0d, required %0d", bus.tline, line);
        end
        if (cyc > 0) begin
            vectors++;
            if (bus.tirq !== exp_irq) begin
                miscompares++;
                $display("FAIL tirq_on_entry line=%0d: tirq=%b, required %b", line, bus.tirq, exp_irq);
            end
        end
        exp_load_q.push_back(NL'(1) << line);
        exp_data_q.push_back(d);
        bus.tbufWR   = 1'b1;
        bus.tbufDATA = d;
        step();
        bus.tbufWR   = 1'b0;
        bus.tbufDATA = 8'h00;
        el = exp_load_q.pop_front();
        ed = exp_data_q.pop_front();
        vectors++;
        if (bus.txload !== el || bus.txdata !== ed) begin
            miscompares++;
            $display("FAIL load_strobe: txload=%b txdata=%h, required txload=%b txdata=%h",
                     bus.txload, bus.txdata, el, ed);
        end
        vectors++;
        if (bus.tirq !== 1'b0) begin
            miscompares++;
            $display("FAIL tirq_width: tirq=%b in load cycle, required 0", bus.tirq);
        end
        if (drop) bus.empty[line] = 1'b0;
        step();
        vectors++;
        if (bus.txload !== '0) begin
            miscompares++;
            $display("FAIL txload_width: txload=%b one cycle after load, required 0", bus.txload);
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        bus.clr = 1'b0; bus.mse = 1'b1; bus.tie = 1'b0;
        bus.tcr = '1; bus.empty = '1;
        bus.tbufWR = 1'b0; bus.tbufDATA = 8'h00;
        step();
        step();
        vectors++;
        if ({bus.trdy, bus.tline, bus.txload, bus.txdata, bus.tirq} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: trdy=%b tline=%0d txload=%b txdata=%h tirq=%b, required all 0",
                     bus.trdy, bus.tline, bus.txload, bus.txdata, bus.tirq);
        end
        rst_n = 1'b1;
        cyc = 0;
        while (bus.trdy !== 1'b1 && cyc < 2) begin
            step();
            cyc++;
        end
        vectors++;
        if (bus.trdy !== 1'b1 || bus.tline !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_first_match: trdy=%b tline=%0d, required trdy=1 tline=0", bus.trdy, bus.tline);
        end
    endtask

    task automatic test_round_robin();
        bit bad;
        for (int n = 0; n < NL; n++) service(n, 8'h41, 1'b1, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.trdy !== 1'b0 || bus.txload !== '0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL all_busy_idle: trdy=%b txload=%b with no empty line, required 0 and 0", bus.trdy, bus.txload);
        end
        bus.empty = '1;
    endtask

    task automatic test_skipping();
        pulse_clr();
        bus.tcr = 8'b0010_0100;
        service(2, 8'h11, 1'b0, 1'b0);
        service(5, 8'h22, 1'b0, 1'b0);
        service(2, 8'h33, 1'b0, 1'b0);
    endtask

    task automatic test_withdrawal();
        logic [NL-1:0] el;
        logic [7:0]    ed;
        int            cyc;
        pulse_clr();
        bus.tcr = '1;
        bus.empty = 8'b0001_1000;
        cyc = 0;
        while (bus.trdy !== 1'b1 && cyc < 10) begin step(); cyc++; end
        vectors++;
        if (bus.trdy !== 1'b1 || bus.tline !== 3'd3) begin
            miscompares++;
            $display("FAIL withdraw_enter: trdy=%b tline=%0d, required trdy=1 tline=3", bus.trdy, bus.tline);
        end
        bus.tcr[3] = 1'b0;
        step();
        vectors++;
        if (bus.trdy !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw_drop: trdy=%b, required 0", bus.trdy);
        end
        step();
        vectors++;
        if (bus.trdy !== 1'b1 || bus.tline !== 3'd4) begin
            miscompares++;
            $display("FAIL withdraw_resume: trdy=%b tline=%0d, required trdy=1 tline=4", bus.trdy, bus.tline);
        end
        bus.tcr = '1;
        pulse_clr();
        cyc = 0;
        while (bus.trdy !== 1'b1 && cyc < 10) begin step(); cyc++; end
        vectors++;
        if (bus.tline !== 3'd3) begin
            miscompares++;
            $display("FAIL withdraw_reenter: tline=%0d, required 3", bus.tline);
        end
        exp_load_q.push_back(8'b0000_1000);
        exp_data_q.push_back(8'h5A);
        bus.tcr[3]   = 1'b0;
        bus.tbufWR   = 1'b1;
        bus.tbufDATA = 8'h5A;
        step();
        bus.tbufWR = 1'b0;
        el = exp_load_q.pop_front();
        ed = exp_data_q.pop_front();
        vectors++;
        if (bus.txload !== el || bus.txdata !== ed) begin
            miscompares++;
            $display("FAIL write_beats_withdraw: txload=%b txdata=%h, required txload=%b txdata=%h",
                     bus.txload, bus.txdata, el, ed);
        end
        bus.tcr = '1;
        bus.empty = '1;
    endtask

    task automatic test_ignored_write_and_irq();
        pulse_clr();
        bus.mse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.tbufWR = 1'b1;
            bus.tbufDATA = 8'($urandom_range(0, 255));
            step();
            vectors++;
            if (bus.txload !== '0 || bus.trdy !== 1'b0) begin
                miscompares++;
                $display("FAIL ignored_write: txload=%b trdy=%b with mse=0, required 0 and 0", bus.txload, bus.trdy);
            end
        end
        bus.tbufWR = 1'b0;
        bus.tie = 1'b1;
        bus.mse = 1'b1;
        service(0, 8'hA0, 1'b1, 1'b1);
        service(1, 8'hA1, 1'b1, 1'b1);
        bus.tie = 1'b0;
        service(2, 8'hA2, 1'b1, 1'b0);
        bus.empty = '1;
    endtask

    task automatic test_clr_during_load();
        logic [NL-1:0] el;
        logic [7:0]    ed;
        int            cyc;
        pulse_clr();
        cyc = 0;
        while (bus.trdy !== 1'b1 && cyc < 10) begin step(); cyc++; end
        exp_load_q.push_back(8'b0000_0001);
        exp_data_q.push_back(8'hC3);
        bus.tbufWR = 1'b1;
        bus.tbufDATA = 8'hC3;
        step();
        bus.tbufWR = 1'b0;
        el = exp_load_q.pop_front();
        ed = exp_data_q.pop_front();
        vectors++;
        if (bus.txload !== el || bus.txdata !== ed) begin
            miscompares++;
            $display("FAIL clr_first_load: txload=%b txdata=%h, required txload=%b txdata=%h",
                     bus.txload, bus.txdata, el, ed);
        end
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        vectors++;
        if ({bus.trdy, bus.tline, bus.txload, bus.txdata, bus.tirq} !== '0) begin
            miscompares++;
            $display("FAIL clr_outputs: trdy=%b tline=%0d txload=%b txdata=%h tirq=%b, required all 0",
                     bus.trdy, bus.tline, bus.txload, bus.txdata, bus.tirq);
        end
        step();
        vectors++;
        if (bus.trdy !== 1'b1 || bus.tline !== 3'd0 || bus.txload !== '0) begin
            miscompares++;
            $display("FAIL clr_restart: trdy=%b tline=%0d txload=%b, required trdy=1 tline=0 txload=0",
                     bus.trdy, bus.tline, bus.txload);
        end
        vectors++;
        if (exp_load_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_load_q.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_skipping();
        test_withdrawal();
        test_ignored_write_and_irq();
        test_clr_during_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dz_tx_scanner.md
# dz_tx_scanner

Transmit scanner for the DZ11 multiplexer. It round-robins over the per-line UART transmitters and finds the next line that is enabled in TCR and has an empty transmitter. It presents that line to the CSR as TRDY/TLINE, then steers the next CPU write of TBUF into that line's transmitter as a single-cycle load. It sits between the DZ11 register file and the array of unbuffered UART transmitters.

## Interface
Parameters:
- NLINES, 8, number of serial lines scanned; power of two, 1 to 16.
- LW, $clog2(NLINES) (minimum 1), width of line number.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous clear, from CSR CLR bit.
- mse  in  1  master scan enable, from CSR.
- tie  in  1  transmit interrupt enable, from CSR.
- tcr  in  NLINES  per-line transmit enable, from TCR.
- empty  in  NLINES  per-line transmitter-empty flags, from the UART transmitters.
- tbufWR  in  1  one-cycle strobe: CPU write to TBUF.
- tbufDATA  in  8  TBUF write data.
- trdy  out  1  transmitter ready (CSR TRDY).
- tline  out  LW  line number of the ready transmitter (CSR TLINE).
- txload  out  NLINES  one-hot, one-cycle load strobe to the transmitters.
- txdata  out  8  character to the transmitters; held stable while txload is asserted.
- tirq  out  1  one-cycle transmit interrupt pulse.

## Operation
- All outputs are registered.
- Reset values: trdy=0, tline=0, txload=0, txdata=0, tirq=0. Internal state is SCAN and the scan pointer ptr=0.
- clr has the same effect as reset, synchronously. clr takes priority over every other input.

State machine:
- **SCAN**
  - If mse=0: hold ptr, stay in SCAN.
  - Else if tcr[ptr] & empty[ptr]: set tline<=ptr and trdy<=1, set tirq<=tie for one cycle, go to READY.
  - Else: ptr<=ptr+1, wrapping from NLINES-1 to 0, stay in SCAN.
- **READY** (trdy=1, tline stable)
  - If tbufWR: set txdata<=tbufDATA, txload[tline]<=1, trdy<=0, go to LOAD.
  - Else if mse=0 or tcr[tline]=0: trdy<=0, ptr<=tline+1 (wrapping), go to SCAN.
  - Else stay in READY.
  - tbufWR wins over a simultaneous tcr or mse drop: the character is loaded.
- **LOAD**
  - txload is high for exactly this cycle; it clears on exit.
  - Set ptr<=tline+1 (wrapping), go to SETTLE.
- **SETTLE**
  - Lasts one cycle, so the loaded UART can drop empty before it is scanned again. This matters when NLINES=1.
  - Go to SCAN.

Boundary conditions:
- tbufWR outside READY is ignored: no load, data discarded.
- A line whose empty goes high while it is not at ptr is found on the next pass. Worst-case latency from empty rising to trdy is NLINES+1 cycles.
- At most one txload bit is ever set.
- Fairness: after servicing line n, scanning resumes at n+1. One busy line cannot starve the others.

## Timing
- SCAN examines one line per clk.
- trdy and tline rise together, in the cycle after the match is evaluated.
- tirq rises together with trdy and lasts one cycle, gated by tie as sampled when READY is entered.
- txload is asserted in the cycle after tbufWR, and txdata is valid in that same cycle.
- From tbufWR to the next possible trdy: minimum 3 cycles (LOAD, SETTLE, SCAN match).
- Reset or clr during LOAD drops the pending load. The UART then sees no strobe, or at most the one already issued.

## Structure
- State encodings (SCAN, READY, LOAD, SETTLE) go in a localparam block in the shared dzuart header, alongside the UART constants.
- A one-hot decoder for txload from tline is a natural sub-module: dz_line_decode (LW in, NLINES out, with an enable input).
- The rest of the block is a single always block plus output registers.

## Test plan
- Reset: hold rst_n=0, set mse=1, tcr=8'hFF, empty=8'hFF, release -> within 2 cycles trdy=1 with tline=0. Before release, all outputs are 0.
- Round-robin: tcr=8'hFF, empty=8'hFF, write TBUF with 8'h41 on each trdy, model the UART dropping empty one cycle after its load -> tline sequence is 0,1,…,7 and txload[n] pulses once each with txdata=8'h41.
- Skipping: tcr=8'b0010_0100, empty=8'hFF, ptr at 0 -> tline=2, then 5 after a write, then 2 again; no other line loaded.
- Withdrawal: in READY at tline=3, drop tcr[3] -> trdy=0 next cycle and scanning resumes at line 4. tcr[3] drop in the same cycle as tbufWR -> load still occurs on line 3.
- Ignored write and interrupt: tbufWR in SCAN with mse=0 -> txload stays 0. tie=1 -> exactly one tirq pulse per READY entry; tie=0 -> no tirq.
- Mid-operation clr: assert clr during LOAD -> next cycle all outputs are 0, ptr=0, state is SCAN, and no second txload is issued.
